audio_stream_fetcher: RTL and testbench

- Streams 16-bit signed PCM samples for the rhythm game's music track from SDRAM into a small FIFO.
- Issues single-word reads on the SDRAM bridge port, one request at a time; this port sits as a requester behind the SDRAM arbiter.
- Pops one sample per sample_tick toward the audio output path.
- Handles start/stop, looping and underrun reporting so software only programs base address and length.

---
 rtl/audio_stream_fetcher.sv | 205 ++++++++++++++++++++
 tb/tb_audio_stream_fetcher.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/audio_stream_fetcher.sv
// Streams 16-bit PCM samples from SDRAM into a sample FIFO and plays one sample per tick.
// Optional AUDIO_VOLUME_EN adds vol_shift_i-style attenuation via the vol_shift port at pop time.
module audio_stream_fetcher #(
    parameter int ADDR_W     = 25,
    parameter int FIFO_DEPTH = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              stop,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [23:0]       num_samples,
    input  logic              loop_en,
    input  logic              sample_tick,
`ifdef AUDIO_VOLUME_EN
    input  logic [2:0]        vol_shift,
`endif
    output logic [15:0]       sample_out,
    output logic              sample_valid,
    output logic              busy,
    output logic              underrun,
    output logic              done,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_read,
    output logic [1:0]        mem_be,
    input  logic              mem_ack,
    input  logic [15:0]       mem_rddata
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] ROOM_MAX = CW'(FIFO_DEPTH - 2);
    localparam logic [CW-1:0] ONE      = CW'(1);

    typedef enum logic [1:0] {IDLE, REQ, GAP, DRAIN} state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [23:0]       num_q, num_d;
    logic [23:0]       fetch_cnt_q, fetch_cnt_d;
    logic              loop_q, loop_d;
    logic              stop_pend_q, stop_pend_d;
    logic              underrun_q, underrun_d;
    logic              done_q, done_d;

    logic [15:0]       fifo_q [FIFO_DEPTH];
    logic [PW-1:0]     wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]     count_q, count_d;
    logic              push, pop, starve, flush;

    logic [15:0]       sample_out_q, popped;
    logic              sample_valid_q;

    assign pop    = sample_tick && (state_q != IDLE) && (count_q != '0);
    assign starve = sample_tick && (state_q != IDLE) && (count_q == '0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            base_q      <= '0;
            num_q       <= '0;
            fetch_cnt_q <= '0;
            loop_q      <= 1'b0;
            stop_pend_q <= 1'b0;
            underrun_q  <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            base_q      <= base_d;
            num_q       <= num_d;
            fetch_cnt_q <= fetch_cnt_d;
            loop_q      <= loop_d;
            stop_pend_q <= stop_pend_d;
            underrun_q  <= underrun_d;
            done_q      <= done_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        base_d      = base_q;
        num_d       = num_q;
        fetch_cnt_d = fetch_cnt_q;
        loop_d      = loop_q;
        stop_pend_d = stop_pend_q;
        underrun_d  = underrun_q;
        done_d      = 1'b0;
        push        = 1'b0;
        flush       = 1'b0;
        case (state_q)
            IDLE: begin
                if (start && !stop) begin
                    underrun_d = 1'b0;
                    if (num_samples != '0) begin
                        base_d      = base_addr;
                        num_d       = num_samples;
                        loop_d      = loop_en;
                        fetch_cnt_d = '0;
                        stop_pend_d = 1'b0;
                        flush       = 1'b1;
                        state_d     = REQ;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            // A started bus cycle always runs to its ack; an abort only discards the data.
            REQ: begin
                if (mem_ack) begin
                    if (stop_pend_q || stop) begin
                        stop_pend_d = 1'b0;
                        flush       = 1'b1;
                        state_d     = IDLE;
                    end else begin
                        push        = 1'b1;
                        fetch_cnt_d = fetch_cnt_q + 24'd1;
                        state_d     = GAP;
                    end
                end else if (stop) begin
                    stop_pend_d = 1'b1;
                end
            end
            GAP: begin
                if (stop) begin
                    flush   = 1'b1;
                    state_d = IDLE;
                end else if (fetch_cnt_q == num_q && !loop_q) begin
                    state_d = DRAIN;
                end else begin
                    if (fetch_cnt_q == num_q) fetch_cnt_d = '0;
                    if (count_q <= ROOM_MAX) state_d = REQ;
                end
            end
            DRAIN: begin
                if (stop) begin
                    flush   = 1'b1;
                    state_d = IDLE;
                end else if (count_q == '0 || (pop && count_q == ONE)) begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        if (starve) underrun_d = 1'b1;
    end

    always_comb begin
        busy     = (state_q != IDLE);
        mem_read = (state_q == REQ);
        mem_addr = mem_read ? (base_q + ADDR_W'(fetch_cnt_q)) : '0;
        mem_be   = 2'b11;
    end

    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + ONE;
            2'b01:   count_d = count_q - ONE;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) fifo_q[wr_ptr_q] <= mem_rddata;
    end

`ifdef AUDIO_VOLUME_EN
    assign popped = $signed(fifo_q[rd_ptr_q]) >>> vol_shift;
`else
    assign popped = fifo_q[rd_ptr_q];
`endif

    // A starved tick outputs silence rather than repeating the previous sample.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sample_out_q   <= '0;
            sample_valid_q <= 1'b0;
        end else begin
            sample_valid_q <= pop;
            if (pop)         sample_out_q <= popped;
            else if (starve) sample_out_q <= '0;
        end
    end

    assign sample_out   = sample_out_q;
    assign sample_valid = sample_valid_q;
    assign underrun     = underrun_q;
    assign done         = done_q;
endmodule

// File: tb/tb_audio_stream_fetcher.sv
// Directed bench for audio_stream_fetcher with a latency-programmable SDRAM responder.
module tb_audio_stream_fetcher;
    localparam int ADDR_W = 25;

    logic              clk = 1'b0;
    logic              reset, start, stop, loop_en, sample_tick;
    logic [ADDR_W-1:0] base_addr;
    logic [23:0]       num_samples;
    logic [15:0]       sample_out;
    logic              sample_valid, busy, underrun, done;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_read, mem_ack;
    logic [1:0]        mem_be;
    logic [15:0]       mem_rddata;
`ifdef AUDIO_VOLUME_EN
    logic [2:0]        vol_shift = 3'd0;
`endif

    int compared = 0, mismatched = 0;
    int ackLat = 3, waitCnt = 0, readCnt = 0, holdErr = 0, gapRun = 0, gapMax = 0;
    int doneCnt = 0, validCnt = 0, doneAtValid = 0;
    int rc0, d0, v0;
    logic              prevRead = 1'b0;
    logic [ADDR_W-1:0] prevAddr = '0;
    logic [ADDR_W-1:0] addrLog[$];
    logic [15:0]       samples[$];

    audio_stream_fetcher #(.ADDR_W(ADDR_W), .FIFO_DEPTH(16)) dut (
        .clk(clk), .reset(reset), .start(start), .stop(stop),
        .base_addr(base_addr), .num_samples(num_samples), .loop_en(loop_en),
        .sample_tick(sample_tick),
`ifdef AUDIO_VOLUME_EN
        .vol_shift(vol_shift),
`endif
        .sample_out(sample_out), .sample_valid(sample_valid), .busy(busy),
        .underrun(underrun), .done(done), .mem_addr(mem_addr), .mem_read(mem_read),
        .mem_be(mem_be), .mem_ack(mem_ack), .mem_rddata(mem_rddata)
    );

    always #10 clk = ~clk;

    function automatic logic [15:0] memData(input logic [ADDR_W-1:0] a);
        logic [15:0] n;
        n = {12'd0, a[3:0]} + 16'd1;
        return n * 16'h1111;
    endfunction

    function automatic logic [31:0] logAddr(input int i);
        if (addrLog.size() > i) return 32'(addrLog[i]);
        return 32'hFFFF_FFFF;
    endfunction

    function automatic logic [31:0] sampleAt(input int i);
        if (samples.size() > i) return 32'(samples[i]);
        return 32'hFFFF_FFFF;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        compared++;
        if (observed !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [ADDR_W-1:0] b, input logic [23:0] n, input logic l);
        @(negedge clk);
        base_addr = b; num_samples = n; loop_en = l; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
    endtask

    task automatic pulseStop();
        @(negedge clk);
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
    endtask

    task automatic tick();
        @(negedge clk);
        sample_tick = 1'b1;
        @(negedge clk);
        sample_tick = 1'b0;
        @(negedge clk);
    endtask

    task automatic waitReads(input int target, input int budget);
        for (int i = 0; i < budget && readCnt < target; i++) @(negedge clk);
    endtask

    task automatic waitIdle(input string tag, input int budget);
        for (int i = 0; i < budget && busy; i++) @(negedge clk);
        checkOutput(tag, 32'(busy), 32'd0);
    endtask

    // SDRAM bridge model: acks each read ackLat cycles after it appears, logs every granted address.
    initial begin
        mem_ack = 1'b0;
        mem_rddata = '0;
        forever begin
            @(negedge clk);
            mem_ack = 1'b0;
            if (mem_read && prevRead && mem_addr != prevAddr) holdErr++;
            if (mem_read && !prevRead) begin
                if (gapRun > gapMax) gapMax = gapRun;
                gapRun = 0;
            end else if (busy && !mem_read) gapRun++;
            else if (!busy) gapRun = 0;
            prevRead = mem_read;
            prevAddr = mem_addr;
            if (mem_read) begin
                waitCnt++;
                if (waitCnt >= ackLat) begin
                    mem_ack    = 1'b1;
                    mem_rddata = memData(mem_addr);
                    addrLog.push_back(mem_addr);
                    readCnt++;
                    waitCnt = 0;
                end
            end else begin
                waitCnt = 0;
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (sample_valid) begin
                validCnt++;
                samples.push_back(sample_out);
            end
            if (done) begin
                doneCnt++;
                doneAtValid = validCnt;
            end
        end
    end

    initial begin
        reset = 1'b1; start = 1'b0; stop = 1'b0; base_addr = '0;
        num_samples = '0; loop_en = 1'b0; sample_tick = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_mem_read", 32'(mem_read), 32'd0);
        checkOutput("rst_mem_addr", 32'(mem_addr), 32'd0);
        checkOutput("rst_sample_out", 32'(sample_out), 32'd0);
        checkOutput("rst_flags", {28'd0, sample_valid, underrun, done, 1'b0}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        // Basic fetch of four words with a three-cycle bridge latency.
        ackLat = 3; gapMax = 0; holdErr = 0;
        addrLog.delete(); samples.delete();
        rc0 = readCnt; d0 = doneCnt; v0 = validCnt;
        applyStimulus(25'h100, 24'd4, 1'b0);
        waitReads(rc0 + 4, 200);
        checkOutput("basic_reads", 32'(readCnt - rc0), 32'd4);
        for (int i = 0; i < 4; i++) checkOutput("basic_addr", logAddr(i), 32'h100 + 32'(i));
        checkOutput("basic_gap", 32'(gapMax), 32'd1);
        checkOutput("basic_hold", 32'(holdErr), 32'd0);
        checkOutput("basic_busy_drain", 32'(busy), 32'd1);
        for (int i = 0; i < 4; i++) begin
            tick();
            repeat (2) @(negedge clk);
        end
        checkOutput("basic_s0", sampleAt(0), 32'h1111);
        checkOutput("basic_s1", sampleAt(1), 32'h2222);
        checkOutput("basic_s2", sampleAt(2), 32'h3333);
        checkOutput("basic_s3", sampleAt(3), 32'h4444);
        checkOutput("basic_done_cnt", 32'(doneCnt - d0), 32'd1);
        checkOutput("basic_done_at_pop", 32'(doneAtValid - v0), 32'd4);
        checkOutput("basic_busy_end", 32'(busy), 32'd0);

        // Backpressure: FIFO of 16 holds at most 15 before the fetcher waits.
        ackLat = 1; samples.delete();
        rc0 = readCnt;
        applyStimulus(25'h000, 24'd64, 1'b0);
        repeat (200) @(negedge clk);
        checkOutput("bp_reads_full", 32'(readCnt - rc0), 32'd15);
        checkOutput("bp_busy", 32'(busy), 32'd1);
        tick();
        repeat (50) @(negedge clk);
        checkOutput("bp_reads_after_tick", 32'(readCnt - rc0), 32'd16);
        checkOutput("bp_sample", sampleAt(0), 32'h1111);
        pulseStop();
        waitIdle("bp_stop_idle", 50);

        // Looping over a three-sample track.
        ackLat = 1; addrLog.delete(); samples.delete();
        d0 = doneCnt;
        applyStimulus(25'h200, 24'd3, 1'b1);
        repeat (80) @(negedge clk);
        checkOutput("loop_addr2", logAddr(2), 32'h202);
        checkOutput("loop_addr3", logAddr(3), 32'h200);
        checkOutput("loop_addr4", logAddr(4), 32'h201);
        for (int i = 0; i < 7; i++) begin
            tick();
            repeat (2) @(negedge clk);
        end
        checkOutput("loop_s2", sampleAt(2), 32'h3333);
        checkOutput("loop_s3", sampleAt(3), 32'h1111);
        checkOutput("loop_s5", sampleAt(5), 32'h3333);
        checkOutput("loop_s6", sampleAt(6), 32'h1111);
        checkOutput("loop_busy", 32'(busy), 32'd1);
        pulseStop();
        waitIdle("loop_stop_idle", 50);
        checkOutput("loop_no_done", 32'(doneCnt - d0), 32'd0);

        // Underrun: slow memory starves the first tick.
        ackLat = 200; samples.delete();
        v0 = validCnt;
        applyStimulus(25'h100, 24'd2, 1'b0);
        repeat (50) @(negedge clk);
        tick();
        checkOutput("ur_flag", 32'(underrun), 32'd1);
        checkOutput("ur_silence", 32'(sample_out), 32'd0);
        checkOutput("ur_no_valid", 32'(validCnt - v0), 32'd0);
        repeat (200) @(negedge clk);
        tick();
        checkOutput("ur_late_sample", sampleAt(0), 32'h1111);
        pulseStop();
        waitIdle("ur_stop_idle", 500);
        checkOutput("ur_sticky", 32'(underrun), 32'd1);
        d0 = doneCnt;
        applyStimulus(25'h000, 24'd0, 1'b0);
        checkOutput("ur_cleared", 32'(underrun), 32'd0);
        checkOutput("zero_len_done", 32'(doneCnt - d0), 32'd1);
        checkOutput("zero_len_busy", 32'(busy), 32'd0);

        // Stop while a read is outstanding: bus cycle completes, data is discarded.
        ackLat = 6;
        rc0 = readCnt; d0 = doneCnt; v0 = validCnt;
        applyStimulus(25'h300, 24'd4, 1'b0);
        pulseStop();
        checkOutput("stopreq_read_held", 32'(mem_read), 32'd1);
        waitIdle("stopreq_idle", 50);
        checkOutput("stopreq_reads", 32'(readCnt - rc0), 32'd1);
        checkOutput("stopreq_no_done", 32'(doneCnt - d0), 32'd0);
        tick();
        checkOutput("stopreq_no_valid", 32'(validCnt - v0), 32'd0);
        checkOutput("idle_tick_hold", 32'(sample_out), 32'h1111);

        // Asynchronous reset in the middle of a request.
        ackLat = 50;
        applyStimulus(25'h100, 24'd4, 1'b0);
        repeat (3) @(negedge clk);
        checkOutput("rstreq_pre_read", 32'(mem_read), 32'd1);
        @(posedge clk);
        #2 reset = 1'b1;
        #1;
        checkOutput("rstreq_mem_read", 32'(mem_read), 32'd0);
        checkOutput("rstreq_busy", 32'(busy), 32'd0);
        checkOutput("rstreq_sample_out", 32'(sample_out), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        rc0 = readCnt; d0 = doneCnt;
        applyStimulus(25'h000, 24'd0, 1'b0);
        checkOutput("rst_zero_done", 32'(doneCnt - d0), 32'd1);
        checkOutput("rst_zero_busy", 32'(busy), 32'd0);
        repeat (10) @(negedge clk);
        checkOutput("rst_zero_no_reads", 32'(readCnt - rc0), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
